fpga_cfg_loader: RTL

Parametrised configuration loader for the fpga fabric family (3x3 today, NxN next). Accepts the configuration bitstream as a stream of DATA_W-bit words over a valid/ready handshake and verifies a trailing XOR checksum. Only on a good checksum does it commit the result to the fabric's parallel bitstream input, and it holds the fabric in reset until then. It replaces the current practice of driving the full-width bitstream directly.

---
 rtl/fpga_cfg_pkg.sv | 17 +
 rtl/fpga_cfg_shift.sv | 33 +++
 rtl/fpga_cfg_loader.sv | 122 ++++++++++++
 3 files changed

// File: rtl/fpga_cfg_pkg.sv
// Shared types and helpers for the fabric configuration loader.
package fpga_cfg_pkg;

    localparam int FPGA3X3_CFG_BITS = 116;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        CHECK  = 2'd2,
        COMMIT = 2'd3
    } cfg_state_t;

    function automatic int cfg_num_words(input int cfg_bits, input int data_w);
        return (cfg_bits + data_w - 1) / data_w;
    endfunction

endpackage

// File: rtl/fpga_cfg_shift.sv
// Shadow shift register, XOR accumulator and word counter for one load.
// Latency: state updates on the edge a word is enabled.
// Backpressure: none of its own; the caller gates en.
module fpga_cfg_shift #(
    parameter int CFG_BITS = 116,
    parameter int DATA_W   = 8,
    parameter int CNT_W    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                en,
    input  logic [DATA_W-1:0]   word,
    output logic [CFG_BITS-1:0] shadow,
    output logic [DATA_W-1:0]   acc,
    output logic [CNT_W-1:0]    count
);

    // Only the low CFG_BITS of the word stream are ever committed, so the
    // padding bits of the first word simply fall off the top here.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            shadow <= '0;
            acc    <= '0;
            count  <= '0;
        end else if (en) begin
            shadow <= CFG_BITS'({shadow, word});
            acc    <= acc ^ word;
            count  <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fpga_cfg_loader.sv
// Streams the fabric bitstream in, checks a trailing XOR checksum, commits on success.
// Latency: bitstream/fabric_reset/cfg_done update one cycle after the checksum word.
// Backpressure: cfg_ready high only in LOAD/CHECK and never in a cfg_start cycle.
module fpga_cfg_loader
    import fpga_cfg_pkg::*;
#(
    parameter int CFG_BITS = FPGA3X3_CFG_BITS,
    parameter int DATA_W   = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_start,
    input  logic [DATA_W-1:0]   cfg_data,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    output logic [CFG_BITS-1:0] bitstream,
    output logic                fabric_reset,
    output logic                cfg_busy,
    output logic                cfg_done,
    output logic                cfg_error
);

    localparam int NUM_WORDS = cfg_num_words(CFG_BITS, DATA_W);
    localparam int CNT_W     = $clog2(NUM_WORDS + 1);

    cfg_state_t          state, state_nxt;
    logic [CFG_BITS-1:0] shadow;
    logic [DATA_W-1:0]   acc;
    logic [CNT_W-1:0]    count;
    logic                accept;
    logic                sh_clear, sh_en, start_clr, set_err, do_commit;

    assign cfg_ready = (state == LOAD || state == CHECK) && !cfg_start;
    assign cfg_busy  = (state != IDLE);
    assign accept    = cfg_valid && cfg_ready;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        sh_clear  = 1'b0;
        sh_en     = 1'b0;
        start_clr = 1'b0;
        set_err   = 1'b0;
        do_commit = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_start) begin
                    state_nxt = LOAD;
                    sh_clear  = 1'b1;
                    start_clr = 1'b1;
                end
            end
            LOAD: begin
                if (cfg_start) begin
                    sh_clear = 1'b1;
                end else if (accept) begin
                    sh_en = 1'b1;
                    if (count == CNT_W'(NUM_WORDS - 1)) state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (cfg_start) begin
                    sh_clear  = 1'b1;
                    state_nxt = LOAD;
                end else if (accept) begin
                    if (cfg_data == acc) begin
                        state_nxt = COMMIT;
                    end else begin
                        set_err   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            COMMIT: begin
                do_commit = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bitstream    <= '0;
            fabric_reset <= 1'b1;
            cfg_done     <= 1'b0;
            cfg_error    <= 1'b0;
        end else begin
            if (start_clr) begin
                fabric_reset <= 1'b1;
                cfg_done     <= 1'b0;
                cfg_error    <= 1'b0;
            end
            if (set_err) cfg_error <= 1'b1;
            if (do_commit) begin
                bitstream    <= shadow;
                fabric_reset <= 1'b0;
                cfg_done     <= 1'b1;
            end
        end
    end

    fpga_cfg_shift #(
        .CFG_BITS (CFG_BITS),
        .DATA_W   (DATA_W),
        .CNT_W    (CNT_W)
    ) u_shift (
        .clk    (clk),
        .reset  (reset),
        .clear  (sh_clear),
        .en     (sh_en),
        .word   (cfg_data),
        .shadow (shadow),
        .acc    (acc),
        .count  (count)
    );

endmodule
